// File: rtl/scp_mmio_pkg.sv
// Shared constants, FSM state type and byte-merge helper for the SCP MMIO responder.
package scp_mmio_pkg;

  localparam logic [3:0] OFF_CYCLE   = 4'h0;
  localparam logic [3:0] OFF_SCRATCH = 4'h4;
  localparam logic [3:0] OFF_GPIO    = 4'h8;
  localparam logic [3:0] OFF_HALT    = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mmio_state_e;

  function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/scp_mmio_if.sv
// Request/response handshake bundle between the processor core (master) and an MMIO responder (slave).
interface scp_mmio_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/scp_mmio_responder.sv
// MMIO responder: cycle counter, scratch, GPIO and sticky halt registers behind a
// valid/ready request/response bus with a fixed number of wait states.
module scp_mmio_responder
  import scp_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  scp_mmio_if.slave        bus,
  output logic [7:0]       gpio_o,
  output logic             halt_o,
  output logic [31:0]      halt_code_o
);

  mmio_state_e state_q, state_d;

  logic        ready_q;
  logic [3:0]  wait_cnt_q;
  logic [31:0] cycle_q;
  logic [31:0] scratch_q;
  logic [7:0]  gpio_q;
  logic        halt_q;
  logic [31:0] halt_code_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic        accept;
  logic        enter_resp;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_be;
  logic        dec_err;
  logic [31:0] rd_word;

  // State register and all datapath state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      wait_cnt_q  <= '0;
      cycle_q     <= '0;
      scratch_q   <= '0;
      gpio_q      <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      cycle_q <= cycle_q + 32'd1;

      if (accept) begin
        lat_we     <= bus.req_we;
        lat_addr   <= bus.req_addr;
        lat_wdata  <= bus.req_wdata;
        lat_be     <= bus.req_be;
        wait_cnt_q <= 4'(WAIT_CYCLES - 1);
      end else if (state_q == WAIT && wait_cnt_q != 4'd0) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end

      if (enter_resp) begin
        rdata_q <= rd_word;
        err_q   <= dec_err;
        if (!dec_err && cur_we) begin
          case (cur_addr[3:0])
            OFF_SCRATCH: scratch_q <= apply_be(scratch_q, cur_wdata, cur_be);
            OFF_GPIO:    if (cur_be[0]) gpio_q <= cur_wdata[7:0];
            OFF_HALT: begin
              if (!halt_q) begin
                halt_q      <= 1'b1;
                halt_code_q <= cur_wdata;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (wait_cnt_q == 4'd0) state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    bus.rsp_valid = (state_q == RESP);
    accept        = (state_q == IDLE) && ready_q && bus.req_valid;
    enter_resp    = (state_d == RESP) && (state_q != RESP);
  end

  // With zero wait states the commit edge is the accept edge, so the live
  // request fields are used instead of the not-yet-loaded latches.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
    end else begin
      cur_we    = lat_we;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_be    = lat_be;
    end
  end

  always_comb begin
    dec_err = (cur_addr[31:4] != BASE_ADDR[31:4]) || (cur_addr[1:0] != 2'b00);
    rd_word = '0;
    if (!dec_err && !cur_we) begin
      case (cur_addr[3:0])
        OFF_CYCLE:   rd_word = cycle_q;
        OFF_SCRATCH: rd_word = scratch_q;
        OFF_GPIO:    rd_word = {24'h0, gpio_q};
        OFF_HALT:    rd_word = {31'h0, halt_q};
        default:     rd_word = '0;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign gpio_o        = gpio_q;
  assign halt_o        = halt_q;
  assign halt_code_o   = halt_code_q;

endmodule

// File: tb/tb_scp_mmio_responder.sv
// Scoreboard bench for scp_mmio_responder: expected responses queued at accept, checked at rsp_valid.
module tb_scp_mmio_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          W    = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  gpio;
  logic        halt;
  logic [31:0] halt_code;

  scp_mmio_if bus ();

  scp_mmio_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .gpio_o      (gpio),
    .halt_o      (halt),
    .halt_code_o (halt_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  // Reference model state.
  logic [31:0] m_cycle = '0;
  logic [31:0] m_scratch = '0;
  logic [7:0]  m_gpio = '0;
  logic        m_halt = 1'b0;
  logic [31:0] m_code = '0;

  always @(posedge clk) m_cycle <= rst ? 32'd0 : m_cycle + 32'd1;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = {be[3] ? n[31:24] : o[31:24], be[2] ? n[23:16] : o[23:16],
         be[1] ? n[15:8]  : o[15:8],  be[0] ? n[7:0]   : o[7:0]};
    return m;
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, input string name);
    int n;
    exp_t e, got;
    logic ok;
    logic [31:0] snap_d;
    logic snap_e;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    bus.rsp_ready = (hold == 0);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL %s accept: req_ready never rose", name);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    ok = (addr[31:4] == BASE[31:4]) && (addr[1:0] == 2'b00);
    e.err = !ok;
    e.rdata = '0;
    if (ok && !we) begin
      case (addr[3:0])
        4'h0: e.rdata = m_cycle + 32'(W) - 32'd1;
        4'h4: e.rdata = m_scratch;
        4'h8: e.rdata = {24'h0, m_gpio};
        4'hC: e.rdata = {31'h0, m_halt};
        default: e.rdata = '0;
      endcase
    end else if (ok && we) begin
      case (addr[3:0])
        4'h4: m_scratch = merge(m_scratch, wdata, be);
        4'h8: if (be[0]) m_gpio = wdata[7:0];
        4'hC: if (!m_halt) begin m_halt = 1'b1; m_code = wdata; end
        default: ;
      endcase
    end
    sb.push_back(e);

    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n != W + 1) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, n, W + 1);
    end
    got = sb.pop_front();
    if (bus.rsp_valid !== 1'b1) begin
      bus.rsp_ready = 1'b1;
      return;
    end
    total++;
    if ({bus.rsp_err, bus.rsp_rdata} !== {got.err, got.rdata}) begin
      bad++;
      $display("FAIL %s rsp: err=%b rdata=%h, want err=%b rdata=%h",
               name, bus.rsp_err, bus.rsp_rdata, got.err, got.rdata);
    end
    total++;
    if ({gpio, halt, halt_code} !== {m_gpio, m_halt, m_code}) begin
      bad++;
      $display("FAIL %s regs: gpio=%h halt=%b code=%h, want gpio=%h halt=%b code=%h",
               name, gpio, halt, halt_code, m_gpio, m_halt, m_code);
    end
    if (hold > 0) begin
      snap_d = bus.rsp_rdata;
      snap_e = bus.rsp_err;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        total++;
        if ({bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_rdata} !==
            {1'b1, 1'b0, snap_e, snap_d}) begin
          bad++;
          $display("FAIL %s hold%0d: valid=%b ready=%b err=%b rdata=%h, want 1 0 %b %h",
                   name, i, bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_rdata,
                   snap_e, snap_d);
        end
      end
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, gpio, halt, halt_code} !==
        {1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL %s: ready=%b valid=%b err=%b rdata=%h gpio=%h halt=%b code=%h, want all 0",
               name, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, gpio, halt,
               halt_code);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_vals("reset_vals");
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: req_ready=%b, want 1", bus.req_ready);
    end
  endtask

  task automatic test_cycle();
    issue(1'b0, BASE + 32'h0, 32'h0, 4'h0, 0, "cycle_read");
    issue(1'b1, BASE + 32'h0, 32'hFFFF_FFFF, 4'hF, 0, "cycle_write_ignored");
    issue(1'b0, BASE + 32'h0, 32'h0, 4'h0, 0, "cycle_read2");
  endtask

  task automatic test_scratch();
    issue(1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 4'b1111, 0, "scratch_wr_full");
    issue(1'b1, BASE + 32'h4, 32'h0000_1122, 4'b0011, 0, "scratch_wr_low");
    issue(1'b0, BASE + 32'h4, 32'h0, 4'h0, 0, "scratch_rd");
    total++;
    if (m_scratch !== 32'hDEAD_1122) begin
      bad++;
      $display("FAIL scratch_model: %h, want DEAD1122", m_scratch);
    end
    issue(1'b1, BASE + 32'h4, 32'hAB00_0000, 4'b1000, 0, "scratch_wr_top");
    issue(1'b0, BASE + 32'h4, 32'h0, 4'h0, 0, "scratch_rd2");
  endtask

  task automatic test_gpio();
    issue(1'b1, BASE + 32'h8, 32'h0000_01A5, 4'b0001, 0, "gpio_wr");
    issue(1'b0, BASE + 32'h8, 32'h0, 4'h0, 0, "gpio_rd");
    issue(1'b1, BASE + 32'h8, 32'h0000_003C, 4'b1110, 0, "gpio_wr_no_be0");
    issue(1'b0, BASE + 32'h8, 32'h0, 4'h0, 0, "gpio_rd2");
  endtask

  task automatic test_halt();
    issue(1'b0, BASE + 32'hC, 32'h0, 4'h0, 0, "halt_rd_clear");
    issue(1'b1, BASE + 32'hC, 32'h0000_002A, 4'b0001, 0, "halt_wr1");
    issue(1'b1, BASE + 32'hC, 32'h0000_0099, 4'b1111, 0, "halt_wr2");
    issue(1'b0, BASE + 32'hC, 32'h0, 4'h0, 0, "halt_rd_set");
    total++;
    if ({halt, halt_code} !== {1'b1, 32'h0000_002A}) begin
      bad++;
      $display("FAIL halt_sticky: halt=%b code=%h, want 1 0000002a", halt, halt_code);
    end
  endtask

  task automatic test_decode();
    issue(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0, "dec_above");
    issue(1'b0, BASE + 32'h5, 32'h0, 4'h0, 0, "dec_unaligned");
    issue(1'b1, BASE + 32'h6, 32'h5555_5555, 4'hF, 0, "dec_wr_unaligned");
    issue(1'b1, BASE - 32'h4, 32'h5555_5555, 4'hF, 0, "dec_wr_below");
    issue(1'b0, BASE + 32'h4, 32'h0, 4'h0, 0, "dec_scratch_kept");
  endtask

  task automatic test_backpressure();
    issue(1'b0, BASE + 32'h4, 32'h0, 4'h0, 5, "bp_read");
    issue(1'b1, BASE + 32'h8, 32'h0000_0011, 4'b0001, 3, "bp_write");
  endtask

  task automatic test_reset_mid();
    int n;
    bus.req_we    = 1'b1;
    bus.req_addr  = BASE + 32'h4;
    bus.req_wdata = 32'h1234_5678;
    bus.req_be    = 4'hF;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_norsp%0d: rsp_valid=%b, want 0", i, bus.rsp_valid);
      end
    end
    check_reset_vals("mid_reset_vals");
    rst = 1'b0;
    m_scratch = '0;
    m_gpio    = '0;
    m_halt    = 1'b0;
    m_code    = '0;
    @(posedge clk); #1;
    issue(1'b0, BASE + 32'h4, 32'h0, 4'h0, 0, "post_reset_scratch");
    issue(1'b0, BASE + 32'hC, 32'h0, 4'h0, 0, "post_reset_halt");
    issue(1'b0, BASE + 32'h0, 32'h0, 4'h0, 0, "post_reset_cycle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_cycle();
    test_scratch();
    test_gpio();
    test_halt();
    test_decode();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
